// File: rtl/dm_resp.sv
// Data-memory responder: services load/store requests from an internal word array
// after WAIT wait states and returns a registered one-cycle acknowledge.
module dm_resp #(
   parameter int unsigned AW    = 8,
   parameter int unsigned DW    = 32,
   parameter int unsigned DEPTH = 256,
   parameter int unsigned WAIT  = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [AW-1:0] addr,
   input  logic [DW-1:0] wdata,
   output logic          ack,
   output logic [DW-1:0] rdata,
   output logic          err,
   output logic          busy
);

   localparam logic [1:0]  S_IDLE   = 2'd0;
   localparam logic [1:0]  S_WAIT   = 2'd1;
   localparam logic [1:0]  S_ACK    = 2'd2;
   localparam logic [3:0]  CNT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);
   localparam logic [AW:0] DEPTH_W  = (AW + 1)'(DEPTH);

   logic [DW-1:0] r_mem [DEPTH];

   logic [1:0]    r_state;
   logic [3:0]    r_cnt;
   logic          r_we;
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_ack;
   logic          r_err;
   logic          r_busy;
   logic [DW-1:0] r_rdata;

   logic [1:0]    w_next;
   logic          w_accept;
   logic          w_go_ack;
   logic          w_acc_we;
   logic [AW-1:0] w_acc_addr;
   logic [DW-1:0] w_acc_wdata;
   logic          w_oor;

   // With WAIT=0 the access happens at the accepting edge, so it must use the live fields.
   always_comb begin
      w_acc_we    = r_we;
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      if (r_state == S_IDLE) begin
         w_acc_we    = we;
         w_acc_addr  = addr;
         w_acc_wdata = wdata;
      end
   end

   assign w_oor = ({1'b0, w_acc_addr} >= DEPTH_W);

   always_comb begin
      w_next   = r_state;
      w_accept = 1'b0;
      w_go_ack = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req) begin
               w_accept = 1'b1;
               if (WAIT == 0) begin
                  w_next   = S_ACK;
                  w_go_ack = 1'b1;
               end else begin
                  w_next = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (!req) begin
               w_next = S_IDLE;
            end else if (r_cnt == 4'd0) begin
               w_next   = S_ACK;
               w_go_ack = 1'b1;
            end
         end
         S_ACK:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_rdata <= '0;
      end else begin
         r_state <= w_next;
         r_ack   <= w_go_ack;
         r_err   <= w_go_ack & w_oor;
         r_busy  <= (w_next == S_WAIT);
         if (w_accept) begin
            r_we    <= we;
            r_addr  <= addr;
            r_wdata <= wdata;
            r_cnt   <= CNT_INIT;
         end else if (r_state == S_WAIT && req && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
         end
         if (w_go_ack && !w_acc_we) begin
            r_rdata <= w_oor ? '0 : r_mem[w_acc_addr];
         end
      end
   end

   // Storage is deliberately not reset; reset only blocks a write from landing.
   always_ff @(posedge clk) begin
      if (!rst && w_go_ack && w_acc_we && !w_oor) begin
         r_mem[w_acc_addr] <= w_acc_wdata;
      end
   end

   assign ack   = r_ack;
   assign rdata = r_rdata;
   assign err   = r_err;
   assign busy  = r_busy;

endmodule
